// File: rtl/mmcm_drp_sequencer_if.sv
// Control and DRP signal bundle between standard-select logic, the sequencer and the MMCM.
// slave = sequencer side, master = environment side (selector + MMCM).
interface mmcm_drp_sequencer_if;
    logic        req;
    logic        cfg_sel;
    logic        busy;
    logic        done;
    logic        error;
    logic        cur_cfg;
    logic        mmcm_rst;
    logic [6:0]  daddr;
    logic        den;
    logic        dwe;
    logic [15:0] di;
    logic [15:0] drp_do;
    logic        drdy;
    logic        locked;

    modport slave (
        input  req, cfg_sel, drp_do, drdy, locked,
        output busy, done, error, cur_cfg, mmcm_rst, daddr, den, dwe, di
    );

    modport master (
        output req, cfg_sel, drp_do, drdy, locked,
        input  busy, done, error, cur_cfg, mmcm_rst, daddr, den, dwe, di
    );
endinterface

// File: rtl/mmcm_drp_sequencer.sv
// Holds the MMCM in reset, read-modify-writes a per-config DRP table, then waits for LOCKED.
// Bounded drdy/lock waits; req ignored while busy. AUTO_CFG_ON_RESET_EN: load cfg 0 right after reset.
module mmcm_drp_sequencer #(
    parameter int                     NUM_REGS     = 6,
    parameter logic [NUM_REGS*39-1:0] CFG0_TABLE   = '0,
    parameter logic [NUM_REGS*39-1:0] CFG1_TABLE   = '0,
    parameter int                     DRDY_TIMEOUT = 64,
    parameter int                     LOCK_TIMEOUT = 65535
) (
    input  logic                 i_clk_in12mhz,
    input  logic                 i_reset,
    mmcm_drp_sequencer_if.slave  io_seq
);

    localparam int IDXW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam int MAXT = (DRDY_TIMEOUT > LOCK_TIMEOUT) ? DRDY_TIMEOUT : LOCK_TIMEOUT;
    localparam int CNTW = $clog2(MAXT + 1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_REGS - 1);
    localparam logic [CNTW-1:0] DRDY_LIM = CNTW'(DRDY_TIMEOUT - 1);
    localparam logic [CNTW-1:0] LOCK_LIM = CNTW'(LOCK_TIMEOUT - 1);

`ifdef AUTO_CFG_ON_RESET_EN
    localparam logic AUTO_START = 1'b1;
`else
    localparam logic AUTO_START = 1'b0;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_RST_ON, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT, S_NEXT, S_RST_OFF, S_LOCK_WAIT
    } state_t;

    state_t          r_state, w_state;
    logic [IDXW-1:0] r_idx, w_idx;
    logic [CNTW-1:0] r_cnt, w_cnt;
    logic            r_cfg, w_cfg;
    logic            r_auto, w_auto;
    logic            r_busy, w_busy;
    logic            r_done, w_done;
    logic            r_error, w_error;
    logic            r_cur_cfg, w_cur_cfg;
    logic            r_mmcm_rst, w_mmcm_rst;
    logic            r_den, w_den;
    logic            r_dwe, w_dwe;
    logic [6:0]      r_daddr, w_daddr;
    logic [15:0]     r_di, w_di;
    logic [38:0]     w_entry;
    logic [6:0]      w_addr;
    logic [15:0]     w_mask;
    logic [15:0]     w_data;

    function automatic logic [38:0] f_entry(input logic cfg, input logic [IDXW-1:0] idx);
        logic [38:0] e;
        e = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (idx == IDXW'(i))
                e = cfg ? CFG1_TABLE[39*i +: 39] : CFG0_TABLE[39*i +: 39];
        end
        return e;
    endfunction

    // Index of the entry being worked on next cycle; equals r_idx during the waits.
    always_comb begin
        w_idx = r_idx;
        if (r_state == S_RST_ON)
            w_idx = '0;
        else if (r_state == S_NEXT && r_idx != LAST_IDX)
            w_idx = r_idx + IDXW'(1);
    end

    assign w_entry = f_entry(r_cfg, w_idx);
    assign {w_addr, w_mask, w_data} = w_entry;

    always_comb begin
        w_state   = r_state;
        w_cfg     = r_cfg;
        w_auto    = r_auto;
        w_busy    = r_busy;
        w_done    = 1'b0;
        w_error   = r_error;
        w_cur_cfg = r_cur_cfg;
        w_di      = r_di;
        w_daddr   = r_daddr;
        w_cnt     = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (io_seq.req || r_auto) begin
                    w_cfg   = r_auto ? 1'b0 : io_seq.cfg_sel;
                    w_auto  = 1'b0;
                    w_error = 1'b0;
                    w_busy  = 1'b1;
                    w_state = S_RST_ON;
                end
            end
            S_RST_ON:  w_state = S_RD;
            S_RD:      w_state = S_RD_WAIT;
            S_RD_WAIT: begin
                // Mask bit set keeps the bit already in the MMCM register.
                if (io_seq.drdy) begin
                    w_di    = (io_seq.drp_do & w_mask) | (w_data & ~w_mask);
                    w_state = S_WR;
                end else if (r_cnt >= DRDY_LIM) begin
                    w_error = 1'b1;
                    w_state = S_RST_OFF;
                end
            end
            S_WR:      w_state = S_WR_WAIT;
            S_WR_WAIT: begin
                if (io_seq.drdy) begin
                    w_state = S_NEXT;
                end else if (r_cnt >= DRDY_LIM) begin
                    w_error = 1'b1;
                    w_state = S_RST_OFF;
                end
            end
            S_NEXT:    w_state = (r_idx == LAST_IDX) ? S_RST_OFF : S_RD;
            S_RST_OFF: begin
                // A DRP timeout still releases reset but skips the lock wait.
                if (r_error) begin
                    w_busy  = 1'b0;
                    w_state = S_IDLE;
                end else begin
                    w_state = S_LOCK_WAIT;
                end
            end
            S_LOCK_WAIT: begin
                if (io_seq.locked) begin
                    w_done    = 1'b1;
                    w_cur_cfg = r_cfg;
                    w_busy    = 1'b0;
                    w_state   = S_IDLE;
                end else if (r_cnt >= LOCK_LIM) begin
                    w_error = 1'b1;
                    w_busy  = 1'b0;
                    w_state = S_IDLE;
                end
            end
            default:   w_state = S_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state they belong to.
        w_den      = (w_state == S_RD) || (w_state == S_WR);
        w_dwe      = (w_state == S_WR);
        w_mmcm_rst = w_state inside {S_RST_ON, S_RD, S_RD_WAIT, S_WR, S_WR_WAIT, S_NEXT};
        if (w_state == S_RD)
            w_daddr = w_addr;

        // One counter serves both waits: cleared on each den and on entry to the lock wait.
        if (w_state == S_RD || w_state == S_WR || (r_state == S_RST_OFF && w_state == S_LOCK_WAIT))
            w_cnt = '0;
        else if (r_state inside {S_RD, S_RD_WAIT, S_WR, S_WR_WAIT, S_LOCK_WAIT})
            w_cnt = r_cnt + CNTW'(1);
    end

    always_ff @(posedge i_clk_in12mhz or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_cfg      <= 1'b0;
            r_auto     <= AUTO_START;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_cur_cfg  <= 1'b0;
            r_mmcm_rst <= 1'b1;
            r_den      <= 1'b0;
            r_dwe      <= 1'b0;
            r_daddr    <= '0;
            r_di       <= '0;
        end else begin
            r_state    <= w_state;
            r_idx      <= w_idx;
            r_cnt      <= w_cnt;
            r_cfg      <= w_cfg;
            r_auto     <= w_auto;
            r_busy     <= w_busy;
            r_done     <= w_done;
            r_error    <= w_error;
            r_cur_cfg  <= w_cur_cfg;
            r_mmcm_rst <= w_mmcm_rst;
            r_den      <= w_den;
            r_dwe      <= w_dwe;
            r_daddr    <= w_daddr;
            r_di       <= w_di;
        end
    end

    assign io_seq.busy     = r_busy;
    assign io_seq.done     = r_done;
    assign io_seq.error    = r_error;
    assign io_seq.cur_cfg  = r_cur_cfg;
    assign io_seq.mmcm_rst = r_mmcm_rst;
    assign io_seq.den      = r_den;
    assign io_seq.dwe      = r_dwe;
    assign io_seq.daddr    = r_daddr;
    assign io_seq.di       = r_di;

endmodule

// File: doc/mmcm_drp_sequencer.md
Name: mmcm_drp_sequencer

Overview:
- Reprograms the color-clock MMCM at runtime over its DRP port, so one bitstream can switch the color4x clock between two video standards (cfg 0 / cfg 1).
- On request, holds the MMCM in reset and read-modify-writes a fixed register table for the selected config. It then releases reset, waits for LOCKED and reports done or error.
- Sits between the standard-select logic and the MMCM instance. Runs in the 12 MHz input clock domain, which also drives DCLK.

Parameters:
- NUM_REGS, 6, entries per config table (max 16).
- CFG0_TABLE, 0, NUM_REGS*39-bit flattened table for cfg 0. Entry i is at bits [39*i+38 : 39*i] = {addr[6:0], mask[15:0], data[15:0]}.
- CFG1_TABLE, 0, same layout for cfg 1.
- DRDY_TIMEOUT, 64, max cycles from den to drdy.
- LOCK_TIMEOUT, 65535, max cycles from reset release to locked.

Ports:
- clk_in12mhz  in  1  12 MHz clock; also drives MMCM DCLK.
- reset  in  1  asynchronous, active-high.
- req  in  1  single-cycle reconfiguration request.
- cfg_sel  in  1  config to load; sampled with req.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse on successful lock.
- error  out  1  sticky failure flag.
- cur_cfg  out  1  last successfully loaded config.
- mmcm_rst  out  1  MMCM RST.
- daddr  out  7  DRP address.
- den  out  1  DRP enable.
- dwe  out  1  DRP write enable.
- di  out  16  DRP write data.
- drp_do  in  16  DRP read data.
- drdy  in  1  DRP ready.
- locked  in  1  MMCM LOCKED.

Behaviour:
- Reset values: busy=0, done=0, error=0, cur_cfg=0, mmcm_rst=1, den=0, dwe=0, daddr=0, di=0. State=IDLE, idx=0, counters 0.
- mmcm_rst is driven 0 from the first IDLE cycle after reset deassertion.
- States: IDLE, RST_ON, RD, RD_WAIT, WR, WR_WAIT, NEXT, RST_OFF, LOCK_WAIT.
- IDLE: on req=1, latch cfg_sel, clear error, set busy, go to RST_ON. req is ignored in every state other than IDLE.
- RST_ON: mmcm_rst=1, idx=0, go to RD.
- RD: den=1 and dwe=0 for exactly one cycle, daddr = entry[idx].addr, go to RD_WAIT.
- RD_WAIT: wait for drdy. On drdy, register di = (drp_do & mask) | (data & ~mask), go to WR. Mask bit 1 means keep the existing bit.
- WR: den=1 and dwe=1 for exactly one cycle with the same daddr, go to WR_WAIT.
- WR_WAIT: on drdy go to NEXT.
- NEXT: if idx == NUM_REGS-1 go to RST_OFF, else idx+1 and go to RD.
- RST_OFF: mmcm_rst=0, go to LOCK_WAIT.
- LOCK_WAIT: locked=1 gives done pulse for one cycle, cur_cfg = latched cfg, busy=0, go to IDLE.
- DRDY timeout: counter resets at each den and increments in RD_WAIT/WR_WAIT. At count == DRDY_TIMEOUT: error=1, go to RST_OFF, then IDLE without done. cur_cfg is unchanged.
- LOCK timeout: counter increments in LOCK_WAIT. At LOCK_TIMEOUT: error=1, busy=0, return to IDLE, no done.
- locked is ignored outside LOCK_WAIT.
- error persists until the next accepted req.
- Stray drdy outside the wait states is ignored.
- Asynchronous reset mid-sequence aborts immediately to the reset values, leaving mmcm_rst=1 while reset is held. A partial table may remain in the MMCM; the next req rewrites it fully.
- Minimum sequence length: 2 + NUM_REGS*(4 + 2 DRP latency) + 1 + lock time.

Optional Feature:
- AUTO_CFG_ON_RESET_EN defined: after reset deasserts, the block behaves as if req=1 with cfg_sel=0 arrived in the first IDLE cycle. mmcm_rst stays 1 continuously from reset through the end of table load, and busy=1 from the first cycle after reset.
- Not defined: the block idles after reset, and mmcm_rst drops to 0 on the first cycle.

Test Plan:
- DRP model with 2-cycle drdy, NUM_REGS=2. Entry0={7'h08, 16'hF000, 16'h0A0B}, reg 8 preset to 16'h1234. req with cfg_sel=1 -> final write di=16'h1A0B; den pulses exactly 4 times; mmcm_rst high for the whole table load; locked raised 10 cycles after RST_OFF -> one done pulse, cur_cfg=1, busy=0.
- drdy never returns on the 2nd read, DRDY_TIMEOUT=64 -> error=1 at 64 cycles after den, mmcm_rst=0, no done, cur_cfg unchanged; the next req clears error.
- locked held 0, LOCK_TIMEOUT=100 -> error=1 at LOCK_WAIT+100, busy=0, no done.
- req pulses asserted during RD_WAIT and LOCK_WAIT -> ignored: exactly 2*NUM_REGS DRP accesses, a single done.
- reset asserted in WR_WAIT -> all outputs return to reset values asynchronously, mmcm_rst=1. A subsequent req completes normally.
- With AUTO_CFG_ON_RESET_EN, release reset with no req -> cfg 0 table written, done pulse, cur_cfg=0. mmcm_rst never drops between reset and RST_OFF.
